// File: rtl/pwm_dead_time_pkg.sv
// Shared definitions for the PWM dead-time output stage: FSM state encoding.
`ifndef PWM_DEAD_TIME_PKG_SV
`define PWM_DEAD_TIME_PKG_SV

package pwm_dead_time_pkg;

   localparam int STATE_WIDTH = 3;

   localparam logic [STATE_WIDTH-1:0] STATE_OFF       = 3'd0;
   localparam logic [STATE_WIDTH-1:0] STATE_LOW       = 3'd1;
   localparam logic [STATE_WIDTH-1:0] STATE_DEAD_RISE = 3'd2;
   localparam logic [STATE_WIDTH-1:0] STATE_HIGH      = 3'd3;
   localparam logic [STATE_WIDTH-1:0] STATE_DEAD_FALL = 3'd4;

   typedef enum logic [STATE_WIDTH-1:0] {
      ST_OFF       = STATE_OFF,
      ST_LOW       = STATE_LOW,
      ST_DEAD_RISE = STATE_DEAD_RISE,
      ST_HIGH      = STATE_HIGH,
      ST_DEAD_FALL = STATE_DEAD_FALL
   } dt_state_e;

endpackage

`endif

// File: rtl/pwm_dead_time_inserter.sv
// Dead-time inserter: turns the raw PWM level into a non-overlapping
// high-side/low-side gate drive pair.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   OFF        | disabled or just out of reset, both gates off
//   LOW        | low-side gate on
//   DEAD_RISE  | both off, counting dead time before the high side turns on
//   HIGH       | high-side gate on
//   DEAD_FALL  | both off, counting dead time before the low side turns on
//
// Gate outputs decode straight from the state register, so an async reset
// drops both gates without waiting for a clock.
module dead_time_inserter
   import pwm_dead_time_pkg::*;
#(
   parameter int dead_time_width = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       pwm_raw,
   input  logic [dead_time_width-1:0] dead_time,
   output logic                       pwm_high,
   output logic                       pwm_low
);

   localparam logic [dead_time_width-1:0] dead_one = {{(dead_time_width-1){1'b0}}, 1'b1};

   dt_state_e                  state;
   dt_state_e                  state_nxt;
   logic [dead_time_width-1:0] dead_cnt;
   logic [dead_time_width-1:0] dead_cnt_nxt;
   logic                       dead_zero;
   logic                       cnt_done;

   assign dead_zero = (dead_time == '0);
   assign cnt_done  = (dead_cnt == '0);

   // State register and dead-time down-counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= ST_OFF;
         dead_cnt <= '0;
      end else begin
         state    <= state_nxt;
         dead_cnt <= dead_cnt_nxt;
      end
   end

   // Next-state logic; a dead interval loads its length only when it starts.
   always_comb begin
      state_nxt    = state;
      dead_cnt_nxt = dead_cnt;
      if (!enable) begin
         state_nxt = ST_OFF;
      end else begin
         case (state)
            ST_OFF, ST_LOW: begin
               if (pwm_raw) begin
                  if (dead_zero) begin
                     state_nxt = ST_HIGH;
                  end else begin
                     state_nxt    = ST_DEAD_RISE;
                     dead_cnt_nxt = dead_time - dead_one;
                  end
               end else begin
                  state_nxt = ST_LOW;
               end
            end
            ST_DEAD_RISE: begin
               if (!pwm_raw) begin
                  state_nxt = ST_LOW;
               end else if (cnt_done) begin
                  state_nxt = ST_HIGH;
               end else begin
                  dead_cnt_nxt = dead_cnt - dead_one;
               end
            end
            ST_HIGH: begin
               if (!pwm_raw) begin
                  if (dead_zero) begin
                     state_nxt = ST_LOW;
                  end else begin
                     state_nxt    = ST_DEAD_FALL;
                     dead_cnt_nxt = dead_time - dead_one;
                  end
               end
            end
            ST_DEAD_FALL: begin
               if (pwm_raw) begin
                  state_nxt = ST_HIGH;
               end else if (cnt_done) begin
                  state_nxt = ST_LOW;
               end else begin
                  dead_cnt_nxt = dead_cnt - dead_one;
               end
            end
            default: begin
               state_nxt = ST_OFF;
            end
         endcase
      end
   end

   assign pwm_high = (state == ST_HIGH);
   assign pwm_low  = (state == ST_LOW);

endmodule

// File: rtl/pwm_dead_time.sv
// Single-channel PWM output stage fed by the upstream period counter.
// Compare and dead time are shadowed at period boundaries so mid-period
// writes never produce a partial pulse.
module pwm_dead_time
   import pwm_dead_time_pkg::*;
#(
   parameter int bit_width       = 32,
   parameter int dead_time_width = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [bit_width-1:0]       counter_value,
   input  logic                       counter_overflow,
   input  logic [bit_width-1:0]       compare_value,
   input  logic [dead_time_width-1:0] dead_time,
   output logic                       pwm_raw,
   output logic                       pwm_high,
   output logic                       pwm_low,
   output logic                       update_strobe
);

   logic [bit_width-1:0]       shadow_compare;
   logic [dead_time_width-1:0] shadow_dead;
   logic [bit_width-1:0]       eff_compare;

   // On the period-start cycle the new compare is used directly, so the first
   // count of a period never sees the stale shadow value.
   assign eff_compare = counter_overflow ? compare_value : shadow_compare;

   // Shadow registers track the inputs while disabled and reload at period start.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shadow_compare <= '0;
         shadow_dead    <= '0;
         update_strobe  <= 1'b0;
      end else begin
         if (!enable || counter_overflow) begin
            shadow_compare <= compare_value;
            shadow_dead    <= dead_time;
         end
         update_strobe <= enable && counter_overflow;
      end
   end

   // Registered compare result.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pwm_raw <= 1'b0;
      end else begin
         pwm_raw <= enable && (counter_value < eff_compare);
      end
   end

   dead_time_inserter #(
      .dead_time_width (dead_time_width)
   ) u_dead_time_inserter (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .pwm_raw   (pwm_raw),
      .dead_time (shadow_dead),
      .pwm_high  (pwm_high),
      .pwm_low   (pwm_low)
   );

endmodule

// File: doc/pwm_dead_time.md
Name: pwm_dead_time

Overview:
Single-channel PWM output stage placed directly downstream of the shadowed-overflow period counter. It consumes counter_value and counter_overflow and compares the count against a compare value that is shadowed at period boundaries. It then generates a complementary high-side/low-side pair with programmable dead time, suitable for driving a half-bridge gate driver.

Parameters:
bit_width, 32, width of counter_value and compare_value
dead_time_width, 8, width of dead_time (max dead time 2^dead_time_width-1 cycles)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  1 = run; 0 = both outputs low, shadows track inputs
counter_value  input  bit_width  current count from the upstream period counter
counter_overflow  input  1  one-cycle pulse from upstream; coincides with counter_value==0 (period start)
compare_value  input  bit_width  requested duty compare (high while count < compare)
dead_time  input  dead_time_width  requested dead time in clock cycles
pwm_raw  output  1  registered compare result before dead-time insertion
pwm_high  output  1  high-side gate drive
pwm_low  output  1  low-side gate drive
update_strobe  output  1  one-cycle pulse when shadows reload at a period boundary

Behaviour:
- Reset (reset==0, asynchronous): shadow_compare=0, shadow_dead=0, dead counter=0, state=OFF, pwm_raw=0, pwm_high=0, pwm_low=0, update_strobe=0.
- Shadow load: when enable==0 or counter_overflow==1, shadow_compare<=compare_value and shadow_dead<=dead_time. update_strobe<=1 only in the counter_overflow && enable case, otherwise 0. Mid-period changes to compare_value/dead_time have no effect.
- Effective compare: eff = counter_overflow ? compare_value : shadow_compare. The first cycle of a new period therefore already uses the new value, with no one-cycle glitch.
- pwm_raw <= enable && (counter_value < eff), unsigned comparison. One-cycle latency.
- Duty boundaries:
  - eff==0 gives pwm_raw constantly 0.
  - eff greater than the last count of the period gives pwm_raw constantly 1, with no edge at the period wrap.
- Dead-time FSM states: OFF, LOW, DEAD_RISE, HIGH, DEAD_FALL. Outputs are decoded from the state register:
  - pwm_low=1 only in LOW.
  - pwm_high=1 only in HIGH.
  - pwm_high and pwm_low are never both 1 in any cycle.
- OFF:
  - enable==1 && pwm_raw==0 -> LOW.
  - enable==1 && pwm_raw==1 -> DEAD_RISE with count=shadow_dead-1, or directly HIGH if shadow_dead==0.
- LOW: pwm_raw==1 -> DEAD_RISE (count<=shadow_dead-1), or HIGH if shadow_dead==0.
- DEAD_RISE:
  - pwm_raw==0 -> LOW (pulse shorter than dead time is swallowed; high side never asserts).
  - else count==0 -> HIGH.
  - else count decrements.
- HIGH: pwm_raw==0 -> DEAD_FALL (count<=shadow_dead-1), or LOW if shadow_dead==0.
- DEAD_FALL: symmetric to DEAD_RISE; pwm_raw==1 -> HIGH; count==0 -> LOW.
- Any state: enable==0 -> OFF on the next edge. This has priority over all other transitions.
- Dead time D>0 gives exactly D cycles with both outputs low between one side dropping and the other rising.
- Latency: counter_value edge -> pwm_raw +1 cycle -> pwm_high/pwm_low +2 cycles (D==0) or +2+D cycles (rising side).
- A shadow_dead change takes effect at the next dead interval that starts; a count in progress is not reloaded.
- Reset asserted mid-operation forces both outputs low immediately (asynchronous). After release the block restarts in OFF.

Decomposition:
- Shared include file with `ifndef guard: localparams for the FSM state encoding (STATE_OFF..STATE_DEAD_FALL, 3 bits).
- One sub-module, dead_time_inserter:
  - Inputs: clock, reset, enable, pwm_raw, dead_time.
  - Outputs: pwm_high, pwm_low.
  - Contents: the FSM and dead counter.
- Shadowing and comparison stay in pwm_dead_time.

Test Plan:
- Period 10 (overflow every 10 cycles, count 0..9), compare=3, dead=0 -> pwm_raw high 3 of 10 cycles. pwm_high mirrors pwm_raw delayed 1 cycle; pwm_low is its complement; never both 1.
- Period 10, compare=5, dead=2 -> pwm_high high 3 cycles, pwm_low high 3 cycles, 2 cycles both low at each transition.
- compare changed 3->7 at count 5 -> current period keeps 3 high cycles; next period has 7. update_strobe pulses once, on the overflow cycle.
- compare=0 -> pwm_raw and pwm_high never 1. compare=12 with period 10 -> pwm_raw stays 1 across the wrap, with no low cycle.
- compare=1, dead=3 -> high side never asserts (pulse swallowed); pwm_low drops for at most 1 cycle per period.
- Reset pulled low mid-HIGH -> all outputs 0 asynchronously. enable=0 during DEAD_RISE -> OFF next cycle with both outputs 0; after re-enable, first output is LOW.
